// File: rtl/crc_pkg.sv
// Shared FSM encoding, polynomials and SD frame lengths for the serial CRC frame engines.
package crc_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [6:0]  CRC7_SD     = 7'h09;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;

    localparam int SD_CMD_BITS = 40;
    localparam int SD_BLK_BITS = 4096;
endpackage

// File: rtl/crc_lfsr.sv
// MSB-first serial CRC register: load to INIT, or shift one bit with polynomial feedback.
// o_crc_nxt is the post-step value so the caller can capture it on the stepping edge.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_CCITT),
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic             i_spi_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_din,
    output logic [CRC_W-1:0] o_crc,
    output logic [CRC_W-1:0] o_crc_nxt
);
    logic [CRC_W-1:0] r_crc;
    logic             w_fb;

    assign w_fb      = r_crc[CRC_W-1] ^ i_din;
    assign o_crc_nxt = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    assign o_crc     = r_crc;

    always_ff @(posedge i_spi_clk or posedge i_reset) begin
        if (i_reset) begin
            r_crc <= INIT;
        end else if (i_load) begin
            r_crc <= INIT;
        end else if (i_step) begin
            r_crc <= o_crc_nxt;
        end
    end
endmodule

// File: rtl/crc_frame_engine.sv
// Frames a serial MOSI stream: CRC over DATA_BITS payload bits, then optionally
// runs the received check bits through the same register and reports zero residue.
module crc_frame_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC16_CCITT),
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter int               DATA_BITS = SD_BLK_BITS,
    parameter bit               CHECK_EN  = 1'b1,
    parameter int               CNT_W     = $clog2(DATA_BITS + CRC_W + 1)
) (
    input  logic             i_spi_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_mosi,
    output logic [CRC_W-1:0] o_crc,
    output logic [CRC_W-1:0] o_crc_calc,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_crc_ok
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CRC_W-1:0] r_crc_calc;
    logic [CRC_W-1:0] w_crc_nxt;
    logic             r_done;
    logic             r_crc_ok;
    logic             w_consume;
    logic             w_last_data;
    logic             w_last_check;
    logic             w_done_nxt;

    // start wins over en, so the bit presented alongside start is dropped
    assign w_consume    = ((r_state == ST_DATA) || (r_state == ST_CHECK)) && i_en && !i_start;
    assign w_cnt_inc    = r_bit_cnt + CNT_W'(1);
    assign w_last_data  = w_consume && (r_state == ST_DATA)  && (w_cnt_inc == CNT_W'(DATA_BITS));
    assign w_last_check = w_consume && (r_state == ST_CHECK) && (w_cnt_inc == CNT_W'(DATA_BITS + CRC_W));

    crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .i_spi_clk (i_spi_clk),
        .i_reset   (i_reset),
        .i_load    (i_start),
        .i_step    (w_consume),
        .i_din     (i_mosi),
        .o_crc     (o_crc),
        .o_crc_nxt (w_crc_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (i_start) begin
            w_state_nxt = ST_DATA;
        end else begin
            case (r_state)
                ST_DATA: begin
                    if (w_last_data) begin
                        w_state_nxt = CHECK_EN ? ST_CHECK : ST_DONE;
                        w_done_nxt  = !CHECK_EN;
                    end
                end
                ST_CHECK: begin
                    if (w_last_check) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_spi_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_crc_calc <= '0;
            r_done     <= 1'b0;
            r_crc_ok   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (i_start) begin
                r_bit_cnt <= '0;
                r_crc_ok  <= 1'b0;
            end else if (w_consume) begin
                r_bit_cnt <= w_cnt_inc;
                if (w_last_data) begin
                    r_crc_calc <= w_crc_nxt;
                end
                // zero residue after the received check bits means a clean frame
                if (w_last_check) begin
                    r_crc_ok <= (w_crc_nxt == '0);
                end
            end
        end
    end

    assign o_crc_calc = r_crc_calc;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_busy     = (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign o_done     = r_done;
    assign o_crc_ok   = r_crc_ok;
endmodule
